// File: rtl/cpu_state_dumper_if.sv
// Control, CPU debug-read and dump-stream signals of the run-and-dump sequencer.
// master = sequencer side, slave = harness / sink side.
interface cpu_state_dumper_if #(
    parameter int XLEN  = 32,
    parameter int CYC_W = 16,
    parameter int IDX_W = 7
);
    logic             start;
    logic             abort;
    logic [CYC_W-1:0] run_cycles;
    logic             cpu_rstn;
    logic             cpu_halt;
    logic [4:0]       reg_raddr;
    logic [XLEN-1:0]  reg_rdata;
    logic [IDX_W-1:0] mem_raddr;
    logic [XLEN-1:0]  mem_rdata;
    logic             out_valid;
    logic             out_ready;
    logic             out_is_mem;
    logic [IDX_W-1:0] out_index;
    logic [XLEN-1:0]  out_data;
    logic [CYC_W-1:0] elapsed;
    logic             busy;
    logic             done;

    modport master (
        input  start, abort, run_cycles, reg_rdata, mem_rdata, out_ready,
        output cpu_rstn, cpu_halt, reg_raddr, mem_raddr, out_valid, out_is_mem,
               out_index, out_data, elapsed, busy, done
    );

    modport slave (
        output start, abort, run_cycles, reg_rdata, mem_rdata, out_ready,
        input  cpu_rstn, cpu_halt, reg_raddr, mem_raddr, out_valid, out_is_mem,
               out_index, out_data, elapsed, busy, done
    );
endinterface

// File: rtl/cpu_state_dumper.sv
// Run-and-dump sequencer: reset-hold, timed CPU run, then halt and stream regfile + dmem words.
// Two cycles per word (fetch, present); a stalled word is held in PRESENT until out_ready.
module cpu_state_dumper #(
    parameter int XLEN         = 32,
    parameter int NUM_REGS     = 32,
    parameter int MEM_DEPTH    = 128,
    parameter int RESET_CYCLES = 6,
    parameter int CYC_W        = 16
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    cpu_state_dumper_if.master  bus
);
    localparam int IDX_W  = $clog2((NUM_REGS > MEM_DEPTH) ? NUM_REGS : MEM_DEPTH);
    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RST_HOLD, S_RUN, S_FETCH, S_PRESENT, S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_nxt_state;
    logic [HOLD_W-1:0]  r_hold;
    logic [CYC_W-1:0]   r_run_len;
    logic [CYC_W-1:0]   r_elapsed;
    logic [IDX_W-1:0]   r_index;
    logic               r_is_mem;
    logic [XLEN-1:0]    r_out_data;
    logic [IDX_W-1:0]   w_nxt_index;
    logic               w_nxt_is_mem;
    logic [CYC_W-1:0]   w_el_inc;
    logic               w_start_ok;

    assign w_el_inc   = (&r_elapsed) ? r_elapsed : r_elapsed + CYC_W'(1);
    assign w_start_ok = !bus.abort && bus.start && (r_state == S_IDLE || r_state == S_DONE);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) r_state <= S_IDLE;
        else         r_state <= w_nxt_state;
    end

    // Read addresses follow the next index so the synchronous RAMs return the word by the end of FETCH.
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_index  = r_index;
        w_nxt_is_mem = r_is_mem;
        if (bus.abort) begin
            w_nxt_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        w_nxt_state  = S_RST_HOLD;
                        w_nxt_index  = '0;
                        w_nxt_is_mem = 1'b0;
                    end
                end
                S_RST_HOLD: begin
                    if (r_hold == HOLD_W'(1))
                        w_nxt_state = (r_run_len == '0) ? S_FETCH : S_RUN;
                end
                S_RUN: begin
                    if (w_el_inc == r_run_len) w_nxt_state = S_FETCH;
                end
                S_FETCH: w_nxt_state = S_PRESENT;
                S_PRESENT: begin
                    if (bus.out_ready) begin
                        if (!r_is_mem && r_index == IDX_W'(NUM_REGS - 1)) begin
                            w_nxt_state  = S_FETCH;
                            w_nxt_index  = '0;
                            w_nxt_is_mem = 1'b1;
                        end else if (r_is_mem && r_index == IDX_W'(MEM_DEPTH - 1)) begin
                            w_nxt_state = S_DONE;
                        end else begin
                            w_nxt_state = S_FETCH;
                            w_nxt_index = r_index + IDX_W'(1);
                        end
                    end
                end
                default: w_nxt_state = S_IDLE;
            endcase
        end

        bus.cpu_rstn  = !(r_state == S_IDLE || r_state == S_RST_HOLD);
        bus.cpu_halt  = (r_state == S_FETCH) || (r_state == S_PRESENT) || (r_state == S_DONE);
        bus.out_valid = (r_state == S_PRESENT);
        bus.busy      = (r_state == S_RST_HOLD) || (r_state == S_RUN) ||
                        (r_state == S_FETCH) || (r_state == S_PRESENT);
        bus.done      = (r_state == S_DONE);
        bus.reg_raddr = w_nxt_is_mem ? 5'd0 : w_nxt_index[4:0];
        bus.mem_raddr = w_nxt_is_mem ? w_nxt_index : '0;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_hold     <= '0;
            r_run_len  <= '0;
            r_elapsed  <= '0;
            r_index    <= '0;
            r_is_mem   <= 1'b0;
            r_out_data <= '0;
        end else begin
            r_index  <= w_nxt_index;
            r_is_mem <= w_nxt_is_mem;
            if (w_start_ok) begin
                r_hold    <= HOLD_W'(RESET_CYCLES);
                r_run_len <= bus.run_cycles;
                r_elapsed <= '0;
            end else begin
                if (r_state == S_RST_HOLD) r_hold <= r_hold - HOLD_W'(1);
                if (r_state == S_RUN)      r_elapsed <= w_el_inc;
            end
            if (r_state == S_FETCH)
                r_out_data <= r_is_mem ? bus.mem_rdata : bus.reg_rdata;
        end
    end

    assign bus.elapsed    = r_elapsed;
    assign bus.out_index  = r_index;
    assign bus.out_is_mem = r_is_mem;
    assign bus.out_data   = r_out_data;
endmodule

// File: tb/tb_cpu_state_dumper.sv
// Bench for cpu_state_dumper: random CPU state arrays behind 1-cycle-latency read ports,
// dump stream collected and compared with the expected reg0..regN-1, mem0..memM-1 sequence.
module tb_cpu_state_dumper;
    localparam int XLEN = 32, NUM_REGS = 32, MEM_DEPTH = 128, CYC_W = 16, IDX_W = 7;
    localparam int NWORDS = NUM_REGS + MEM_DEPTH;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    cpu_state_dumper_if #(.XLEN(XLEN), .CYC_W(CYC_W), .IDX_W(IDX_W)) bus ();

    cpu_state_dumper #(
        .XLEN(XLEN), .NUM_REGS(NUM_REGS), .MEM_DEPTH(MEM_DEPTH),
        .RESET_CYCLES(6), .CYC_W(CYC_W)
    ) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    logic [XLEN-1:0] rf [NUM_REGS];
    logic [XLEN-1:0] mm [MEM_DEPTH];

    always @(posedge clk) begin
        bus.reg_rdata <= rf[bus.reg_raddr];
        bus.mem_rdata <= mm[bus.mem_raddr];
    end

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          rdy_mode = 0;
    int          n_low, n_run, stab_err, first_valid, last_low;
    logic        prev_stall;
    logic [39:0] prev_word, cur;
    logic [39:0] log_q [$];

    function automatic logic [39:0] word(input logic m, input int idx, input logic [31:0] d);
        logic [6:0] i7;
        i7 = idx[6:0];
        return {m, i7, d};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: apply ready pattern, observe the cycle, emulate CPU writes while it runs.
    task automatic step();
        if (rdy_mode == 1) bus.out_ready = (cyc % 3 == 0);
        else if (rdy_mode == 2) bus.out_ready = 1'($urandom_range(0, 1));
        #1;
        cur = {bus.out_is_mem, bus.out_index, bus.out_data};
        if (rstn) begin
            if (!bus.cpu_rstn) begin
                n_low++;
                last_low = cyc;
            end
            if (bus.cpu_rstn && !bus.cpu_halt) begin
                n_run++;
                rf[$urandom_range(0, NUM_REGS - 1)]  = $urandom;
                mm[$urandom_range(0, MEM_DEPTH - 1)] = $urandom;
            end
            if (bus.out_valid && first_valid < 0) first_valid = cyc;
            if (prev_stall && bus.out_valid && cur !== prev_word) stab_err++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_word  = cur;
            if (bus.out_valid && bus.out_ready && !bus.abort) log_q.push_back(cur);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_start(input int rc);
        bus.run_cycles = CYC_W'(rc);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_low = 0; n_run = 0; first_valid = -1; last_low = -1;
        stab_err = 0; prev_stall = 1'b0;
        log_q.delete();
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int k = 0; k < budget && !bus.done; k++) step();
        check($sformatf("%s_done", tag), bus.done, 1);
    endtask

    task automatic check_dump(input string tag);
        logic [39:0] exp;
        check($sformatf("%s_nwords", tag), log_q.size(), NWORDS);
        for (int i = 0; i < NWORDS && i < log_q.size(); i++) begin
            exp = (i < NUM_REGS) ? word(1'b0, i, rf[i]) : word(1'b1, i - NUM_REGS, mm[i - NUM_REGS]);
            check($sformatf("%s_word%0d", tag, i), log_q[i], exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cpu_rstn"}, bus.cpu_rstn, 0);
        check({tag, "_cpu_halt"}, bus.cpu_halt, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_is_mem"}, bus.out_is_mem, 0);
        check({tag, "_out_index"}, bus.out_index, 0);
        check({tag, "_out_data"}, bus.out_data, 0);
        check({tag, "_elapsed"}, bus.elapsed, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_reg_raddr"}, bus.reg_raddr, 0);
        check({tag, "_mem_raddr"}, bus.mem_raddr, 0);
    endtask

    initial begin
        int rc, el_before, k;
        for (int i = 0; i < NUM_REGS; i++)  rf[i] = $urandom;
        for (int i = 0; i < MEM_DEPTH; i++) mm[i] = $urandom;
        rstn = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.run_cycles = '0; bus.out_ready = 1'b0;
        #12;
        check_reset_vals("rst");
        @(negedge clk);
        rstn = 1'b1;
        step(); step();

        // T1: long run, sink always ready
        bus.out_ready = 1'b1;
        run_start(400);
        wait_done("t1", 2000);
        check("t1_rst_low", n_low, 6);
        check("t1_run", n_run, 400);
        check("t1_elapsed", bus.elapsed, 400);
        check("t1_halt", bus.cpu_halt, 1);
        check("t1_cpu_rstn", bus.cpu_rstn, 1);
        check("t1_busy", bus.busy, 0);
        check_dump("t1");

        // T2: zero-length run from DONE
        run_start(0);
        wait_done("t2", 1000);
        check("t2_run", n_run, 0);
        check("t2_elapsed", bus.elapsed, 0);
        check("t2_first_valid", first_valid - last_low, 2);
        check_dump("t2");

        // T3: sink ready one cycle in three
        rc = $urandom_range(5, 60);
        run_start(rc);
        rdy_mode = 1;
        wait_done("t3", 3000);
        rdy_mode = 0;
        bus.out_ready = 1'b1;
        check("t3_stable", stab_err, 0);
        check("t3_elapsed", bus.elapsed, rc);
        check_dump("t3");

        // T4: abort while mem word 17 is presented with ready high
        run_start(10);
        for (k = 0; k < 500; k++) begin
            if (bus.out_valid && bus.out_is_mem && bus.out_index == 7'd17) break;
            step();
        end
        check("t4_reached", k < 500, 1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("t4_out_valid", bus.out_valid, 0);
        check("t4_cpu_rstn", bus.cpu_rstn, 0);
        check("t4_cpu_halt", bus.cpu_halt, 0);
        check("t4_busy", bus.busy, 0);
        check("t4_done", bus.done, 0);
        check("t4_elapsed", bus.elapsed, 10);
        check("t4_nwords", log_q.size(), NUM_REGS + 17);
        if (log_q.size() > 0) check("t4_last", log_q[log_q.size() - 1], word(1'b1, 16, mm[16]));

        // T5: start during RUN ignored, start in DONE reruns
        run_start(100);
        for (int i = 0; i < 30; i++) step();
        el_before = int'(bus.elapsed);
        bus.run_cycles = 16'd5;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("t5_ign_busy", bus.busy, 1);
        check("t5_ign_halt", bus.cpu_halt, 0);
        check("t5_ign_elapsed", bus.elapsed, el_before + 1);
        wait_done("t5a", 1000);
        check("t5a_elapsed", bus.elapsed, 100);
        check("t5a_run", n_run, 100);
        check_dump("t5a");
        run_start(20);
        check("t5b_busy", bus.busy, 1);
        check("t5b_elapsed0", bus.elapsed, 0);
        check("t5b_done", bus.done, 0);
        wait_done("t5b", 1000);
        check("t5b_elapsed", bus.elapsed, 20);
        check_dump("t5b");

        // T6: asynchronous reset while reg word 9 is presented
        run_start(7);
        for (k = 0; k < 500; k++) begin
            if (bus.out_valid && !bus.out_is_mem && bus.out_index == 7'd9) break;
            step();
        end
        check("t6_reached", k < 500, 1);
        #2 rstn = 1'b0;
        #1;
        check_reset_vals("t6");
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("t6_nwords", log_q.size(), 9);
        check("t6_idle_busy", bus.busy, 0);
        check("t6_idle_valid", bus.out_valid, 0);
        check("t6_idle_cpu_rstn", bus.cpu_rstn, 0);

        // T7: random run lengths with a random sink
        for (int r = 0; r < 2; r++) begin
            rc = $urandom_range(0, 40);
            run_start(rc);
            rdy_mode = 2;
            wait_done($sformatf("t7_%0d", r), 3000);
            rdy_mode = 0;
            check($sformatf("t7_%0d_stable", r), stab_err, 0);
            check($sformatf("t7_%0d_elapsed", r), bus.elapsed, rc);
            check_dump($sformatf("t7_%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
